// File: rtl/compute_pkg.sv
// Shared definitions for the compute array: opcodes, limb range and scheduler states.
// Also imported by mod_table_50 users, so keep additions generic.
package compute_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_MUL  = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ISSUE = 2'b01,
      S_DRAIN = 2'b10
   } sched_state_e;

   localparam int NUM_LIMBS = 33;
   localparam int LIMB_W    = 6;

   function automatic logic limb_ok(input logic [LIMB_W-1:0] limb);
      return limb < LIMB_W'(NUM_LIMBS);
   endfunction

endpackage

// File: rtl/sched_delay_line.sv
// Fixed-depth shift register carrying a valid bit alongside its payload.
// Asynchronous active-low clear drops everything in flight.
module sched_delay_line #(
   parameter int DEPTH = 2,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         vld_in,
   input  logic [W-1:0] din,
   output logic         vld_out,
   output logic [W-1:0] dout
);

   logic [W:0] stage [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= {vld_in, din};
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign {vld_out, dout} = stage[DEPTH-1];

endmodule

// File: rtl/compute_array_sched.sv
// Command sequencer for compute_array: issues operand reads, aligns op controls with
// arriving data and retires results through the single scratchpad write port.
module compute_array_sched
   import compute_pkg::*;
#(
   parameter int ARRAY_SIZE = 256,
   parameter int ADDR_W     = 12,
   parameter int LEN_W      = 12,
   parameter int RD_LAT     = 2,
   parameter int ADD_LAT    = 1,
   parameter int MUL_LAT    = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [1:0]                   cmd_op,
   input  logic [5:0]                   cmd_limb,
   input  logic [LEN_W-1:0]             cmd_len,
   input  logic [ADDR_W-1:0]            cmd_src0,
   input  logic [ADDR_W-1:0]            cmd_src1,
   input  logic [ADDR_W-1:0]            cmd_dst,
   output logic                         rd_en,
   output logic [ADDR_W-1:0]            rd_addr0,
   output logic [ADDR_W-1:0]            rd_addr1,
   output logic                         ctrl_ma,
   output logic [ARRAY_SIZE*LIMB_W-1:0] limb_id_add_bus,
   output logic [ARRAY_SIZE*LIMB_W-1:0] limb_id_mul_bus,
   output logic                         wr_en,
   output logic                         wr_sel,
   output logic [ADDR_W-1:0]            wr_addr,
   output logic                         busy,
   output logic                         done,
   output logic                         err
);

   localparam int MAX_LAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
   localparam int DRN_W   = $clog2(RD_LAT + MAX_LAT + 1);
   localparam int TAG_W   = 2 + LIMB_W + ADDR_W;

   sched_state_e      state;
   logic [LEN_W-1:0]  beat_left;
   logic [DRN_W-1:0]  drain_cnt;
   logic              is_sub_q, is_mul_q;
   logic [LIMB_W-1:0] limb_q;
   logic [ADDR_W-1:0] wr_addr_p0;
   logic              cmd_bad;

   assign cmd_bad   = (cmd_op == OP_RSVD) || !limb_ok(cmd_limb);
   assign busy      = (state != S_IDLE);
   assign cmd_ready = !busy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         beat_left  <= '0;
         drain_cnt  <= '0;
         is_sub_q   <= 1'b0;
         is_mul_q   <= 1'b0;
         limb_q     <= '0;
         wr_addr_p0 <= '0;
         rd_en      <= 1'b0;
         rd_addr0   <= '0;
         rd_addr1   <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  // Rejected and empty commands retire immediately without traffic.
                  if (cmd_bad || cmd_len == '0) begin
                     done <= 1'b1;
                     err  <= cmd_bad;
                  end else begin
                     state      <= S_ISSUE;
                     rd_en      <= 1'b1;
                     rd_addr0   <= cmd_src0;
                     rd_addr1   <= cmd_src1;
                     wr_addr_p0 <= cmd_dst;
                     beat_left  <= cmd_len - LEN_W'(1);
                     is_sub_q   <= (cmd_op == OP_SUB);
                     is_mul_q   <= (cmd_op == OP_MUL);
                     limb_q     <= cmd_limb;
                  end
               end
            end
            S_ISSUE: begin
               if (beat_left == '0) begin
                  rd_en     <= 1'b0;
                  state     <= S_DRAIN;
                  drain_cnt <= is_mul_q ? DRN_W'(RD_LAT + MUL_LAT - 1)
                                        : DRN_W'(RD_LAT + ADD_LAT - 1);
               end else begin
                  beat_left  <= beat_left - LEN_W'(1);
                  rd_addr0   <= rd_addr0 + ADDR_W'(1);
                  rd_addr1   <= rd_addr1 + ADDR_W'(1);
                  wr_addr_p0 <= wr_addr_p0 + ADDR_W'(1);
               end
            end
            S_DRAIN: begin
               if (drain_cnt == '0) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - DRN_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // p0 -> p1: read latency, tag arrives together with operand data
   logic [TAG_W-1:0]  tag_p0, tag_p1;
   logic              vld_p1, is_sub_p1, is_mul_p1;
   logic [LIMB_W-1:0] limb_p1;
   logic [ADDR_W-1:0] wr_addr_p1;

   assign tag_p0 = {is_sub_q, is_mul_q, limb_q, wr_addr_p0};

   sched_delay_line #(.DEPTH(RD_LAT), .W(TAG_W)) u_align (
      .clk     (clk),
      .rst_n   (rst),
      .vld_in  (rd_en),
      .din     (tag_p0),
      .vld_out (vld_p1),
      .dout    (tag_p1)
   );

   assign {is_sub_p1, is_mul_p1, limb_p1, wr_addr_p1} = tag_p1;

   assign ctrl_ma         = vld_p1 && !is_mul_p1 && is_sub_p1;
   assign limb_id_add_bus = (vld_p1 && !is_mul_p1) ? {ARRAY_SIZE{limb_p1}} : '0;
   assign limb_id_mul_bus = (vld_p1 &&  is_mul_p1) ? {ARRAY_SIZE{limb_p1}} : '0;

   // p1 -> p2: unit latency, write tags emerge with the unit result
   logic              add_vld_p2, mul_vld_p2;
   logic [ADDR_W-1:0] add_addr_p2, mul_addr_p2;

   sched_delay_line #(.DEPTH(ADD_LAT), .W(ADDR_W)) u_add_pipe (
      .clk     (clk),
      .rst_n   (rst),
      .vld_in  (vld_p1 && !is_mul_p1),
      .din     (wr_addr_p1),
      .vld_out (add_vld_p2),
      .dout    (add_addr_p2)
   );

   sched_delay_line #(.DEPTH(MUL_LAT), .W(ADDR_W)) u_mul_pipe (
      .clk     (clk),
      .rst_n   (rst),
      .vld_in  (vld_p1 && is_mul_p1),
      .din     (wr_addr_p1),
      .vld_out (mul_vld_p2),
      .dout    (mul_addr_p2)
   );

   assign wr_en   = add_vld_p2 || mul_vld_p2;
   assign wr_sel  = mul_vld_p2;
   assign wr_addr = mul_vld_p2 ? mul_addr_p2 : (add_vld_p2 ? add_addr_p2 : '0);

endmodule

// File: tb/tb_compute_array_sched.sv
// Randomized and directed bench for compute_array_sched against a per-cycle schedule model.
module tb_compute_array_sched;

   localparam int ARRAY_SIZE = 256;
   localparam int ADDR_W     = 12;
   localparam int LEN_W      = 12;
   localparam int RD_LAT     = 2;
   localparam int ADD_LAT    = 1;
   localparam int MUL_LAT    = 8;
   localparam int NCYC       = 8192;
   localparam int BUS_W      = ARRAY_SIZE * 6;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [1:0]        cmd_op = '0;
   logic [5:0]        cmd_limb = '0;
   logic [LEN_W-1:0]  cmd_len = '0;
   logic [ADDR_W-1:0] cmd_src0 = '0, cmd_src1 = '0, cmd_dst = '0;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr0, rd_addr1;
   logic              ctrl_ma;
   logic [BUS_W-1:0]  limb_id_add_bus, limb_id_mul_bus;
   logic              wr_en, wr_sel;
   logic [ADDR_W-1:0] wr_addr;
   logic              busy, done, err;

   compute_array_sched #(
      .ARRAY_SIZE(ARRAY_SIZE), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
      .RD_LAT(RD_LAT), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_limb(cmd_limb), .cmd_len(cmd_len),
      .cmd_src0(cmd_src0), .cmd_src1(cmd_src1), .cmd_dst(cmd_dst),
      .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
      .ctrl_ma(ctrl_ma), .limb_id_add_bus(limb_id_add_bus),
      .limb_id_mul_bus(limb_id_mul_bus), .wr_en(wr_en), .wr_sel(wr_sel),
      .wr_addr(wr_addr), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit       rd;
      bit [11:0] a0, a1;
      bit       addv, mulv, ctrl;
      bit [5:0] limb;
      bit       wr, sel;
      bit [11:0] wa;
      bit       done, err, busy;
   } exp_t;

   exp_t ex [NCYC];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
      end
   endtask

   // Model: each accepted command is expanded into per-cycle expectations.
   int b, lat, idx;
   bit bad;
   logic [BUS_W-1:0] eb_add, eb_mul;

   always @(negedge clk) begin
      if (cyc < NCYC) begin
         if (!rst)
            for (int i = cyc; i < NCYC; i++) ex[i] = '{default: '0};
         eb_add = ex[cyc].addv ? {ARRAY_SIZE{ex[cyc].limb}} : '0;
         eb_mul = ex[cyc].mulv ? {ARRAY_SIZE{ex[cyc].limb}} : '0;
         chk("rd_en", 32'(rd_en), 32'(ex[cyc].rd));
         if (ex[cyc].rd) begin
            chk("rd_addr0", 32'(rd_addr0), 32'(ex[cyc].a0));
            chk("rd_addr1", 32'(rd_addr1), 32'(ex[cyc].a1));
         end
         if (ex[cyc].addv || !rst) chk("ctrl_ma", 32'(ctrl_ma), 32'(ex[cyc].ctrl));
         checks++;
         if (limb_id_add_bus !== eb_add) begin
            errors++;
            $display("FAIL limb_id_add_bus cyc=%0d lane0 actual=%0d required=%0d", cyc,
                     limb_id_add_bus[5:0], eb_add[5:0]);
         end
         checks++;
         if (limb_id_mul_bus !== eb_mul) begin
            errors++;
            $display("FAIL limb_id_mul_bus cyc=%0d lane0 actual=%0d required=%0d", cyc,
                     limb_id_mul_bus[5:0], eb_mul[5:0]);
         end
         chk("wr_en", 32'(wr_en), 32'(ex[cyc].wr));
         if (ex[cyc].wr || !rst) begin
            chk("wr_addr", 32'(wr_addr), 32'(ex[cyc].wa));
            chk("wr_sel", 32'(wr_sel), 32'(ex[cyc].sel));
         end
         chk("done", 32'(done), 32'(ex[cyc].done));
         chk("err", 32'(err), 32'(ex[cyc].err));
         chk("busy", 32'(busy), 32'(ex[cyc].busy));
         chk("cmd_ready", 32'(cmd_ready), 32'(!ex[cyc].busy));

         if (rst && cmd_valid && cmd_ready) begin
            b   = cyc + 1;
            bad = (cmd_op == 2'b11) || (cmd_limb > 6'd32);
            lat = (cmd_op == 2'b10) ? MUL_LAT : ADD_LAT;
            if (bad || cmd_len == 0) begin
               if (b < NCYC) begin
                  ex[b].done = 1'b1;
                  ex[b].err  = bad;
               end
            end else begin
               for (int k = 0; k < int'(cmd_len); k++) begin
                  idx = b + k;
                  if (idx < NCYC) begin
                     ex[idx].rd = 1'b1;
                     ex[idx].a0 = 12'((int'(cmd_src0) + k) % 4096);
                     ex[idx].a1 = 12'((int'(cmd_src1) + k) % 4096);
                  end
                  idx = b + k + RD_LAT;
                  if (idx < NCYC) begin
                     ex[idx].limb = cmd_limb;
                     ex[idx].mulv = (cmd_op == 2'b10);
                     ex[idx].addv = (cmd_op != 2'b10);
                     ex[idx].ctrl = (cmd_op == 2'b01);
                  end
                  idx = b + k + RD_LAT + lat;
                  if (idx < NCYC) begin
                     ex[idx].wr  = 1'b1;
                     ex[idx].sel = (cmd_op == 2'b10);
                     ex[idx].wa  = 12'((int'(cmd_dst) + k) % 4096);
                  end
               end
               for (int i = b; i < b + int'(cmd_len) + RD_LAT + lat; i++)
                  if (i < NCYC) ex[i].busy = 1'b1;
               idx = b + int'(cmd_len) + RD_LAT + lat;
               if (idx < NCYC) ex[idx].done = 1'b1;
            end
         end
      end
   end

   // Presents a command (caller is just past a posedge) and holds it until accepted.
   // Returns the cycle index of the accepting cycle; cmd_valid stays high on return.
   task automatic send(input logic [1:0] op, input logic [5:0] limb, input int len,
                       input int s0, input int s1, input int d, output int acc);
      bit got = 0;
      cmd_valid = 1'b1;
      cmd_op = op; cmd_limb = limb; cmd_len = LEN_W'(len);
      cmd_src0 = ADDR_W'(s0); cmd_src1 = ADDR_W'(s1); cmd_dst = ADDR_W'(d);
      acc = -1;
      for (int t = 0; t < 300 && !got; t++) begin
         @(negedge clk);
         if (cmd_ready) begin
            got = 1;
            acc = cyc;
         end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL accept_timeout cyc=%0d actual=no_accept required=accept", cyc);
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_done(input string nm, input int acc, input int exp_lat, input bit exp_err);
      bit got = 0;
      for (int t = 0; t < 200 && !got; t++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            chk({nm, "_latency"}, 32'(cyc - acc), 32'(exp_lat));
            chk({nm, "_err"}, 32'(err), 32'(exp_err));
         end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL %s_done_timeout cyc=%0d actual=no_done required=done", nm, cyc);
      end
   endtask

   logic [ADDR_W-1:0] wrap_seq [4];
   int a1, a2, gap;

   initial begin
      for (int i = 0; i < NCYC; i++) ex[i] = '{default: '0};
      wrap_seq[0] = 12'hFFE; wrap_seq[1] = 12'hFFF; wrap_seq[2] = 12'h000; wrap_seq[3] = 12'h001;

      repeat (2) @(negedge clk);
      chk("reset_rd_en", 32'(rd_en), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_wr_en", 32'(wr_en), 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;

      // ADD limb 5, len 4
      send(2'b00, 6'd5, 4, 'h10, 'h20, 'h30, a1);
      cmd_valid = 1'b0;
      chk("add_first_rd_addr0", 32'(rd_addr0), 32'h10);
      wait_done("add", a1, 8, 1'b0);

      // MUL limb 32, len 3
      @(posedge clk); #1;
      send(2'b10, 6'd32, 3, 'h100, 'h200, 'h300, a1);
      cmd_valid = 1'b0;
      wait_done("mul", a1, 14, 1'b0);

      // SUB with wrapping source
      @(posedge clk); #1;
      send(2'b01, 6'd7, 4, 'hFFE, 'h5, 'h40, a1);
      cmd_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("sub_wrap_rd_addr0", 32'(rd_addr0), 32'(wrap_seq[k]));
      end
      wait_done("sub", a1, 8, 1'b0);

      // Rejected and empty commands
      @(posedge clk); #1;
      send(2'b11, 6'd3, 5, 0, 0, 0, a1);
      cmd_valid = 1'b0;
      wait_done("rej_op", a1, 1, 1'b1);
      @(posedge clk); #1;
      send(2'b00, 6'd33, 5, 0, 0, 0, a1);
      cmd_valid = 1'b0;
      wait_done("rej_limb", a1, 1, 1'b1);
      @(posedge clk); #1;
      send(2'b00, 6'd4, 0, 0, 0, 0, a1);
      cmd_valid = 1'b0;
      wait_done("len0", a1, 1, 1'b0);

      // Back-to-back: second command held valid during a MUL
      @(posedge clk); #1;
      send(2'b10, 6'd9, 6, 'h50, 'h60, 'h70, a1);
      send(2'b00, 6'd2, 3, 'h80, 'h90, 'hA0, a2);
      cmd_valid = 1'b0;
      chk("b2b_accept_gap", 32'(a2 - a1), 32'd17);
      wait_done("b2b_add", a2, 7, 1'b0);

      // Reset mid-MUL after two beats issued
      @(posedge clk); #1;
      send(2'b10, 6'd11, 6, 'h400, 'h500, 'h600, a1);
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("midreset_rd_en", 32'(rd_en), 32'd0);
      chk("midreset_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      send(2'b00, 6'd1, 2, 'h10, 'h11, 'h12, a1);
      cmd_valid = 1'b0;
      wait_done("post_reset", a1, 6, 1'b0);

      // Randomized commands, sometimes back-to-back
      for (int n = 0; n < 40; n++) begin
         logic [1:0] op;
         int r;
         r  = int'($urandom_range(0, 9));
         op = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         send(op, 6'($urandom_range(0, 34)), int'($urandom_range(0, 9)),
              int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
              int'($urandom_range(0, 4095)), a1);
         if ($urandom_range(0, 2) != 0) begin
            cmd_valid = 1'b0;
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(posedge clk);
            #1;
         end
      end
      cmd_valid = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
